// File: rtl/blocked_read_ctrl_if.sv
// Read-control bus: block handshake and tile sizes in, bank read addresses and
// completion pulses out. The controller uses the master view, its client the slave view.
interface blocked_read_ctrl_if #(
  parameter int unsigned ADDR_W_A     = 12,
  parameter int unsigned ADDR_W_B     = 12,
  parameter int unsigned MATRIXSIZE_W = 16
);
  logic                    rd_go;
  logic [MATRIXSIZE_W-1:0] M2;
  logic [MATRIXSIZE_W-1:0] M1dN1;
  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2;
  logic [MATRIXSIZE_W-1:0] BLOCKS;
  logic [ADDR_W_A-1:0]     rd_addr_A;
  logic [ADDR_W_B-1:0]     rd_addr_B;
  logic                    rd_valid;
  logic                    tile_first;
  logic                    tile_last;
  logic                    done_read_control;
  logic                    done_multiply;
  logic                    busy;

  modport master (
    input  rd_go, M2, M1dN1, BLOCK_WIDTHdN2, BLOCKS,
    output rd_addr_A, rd_addr_B, rd_valid, tile_first, tile_last,
           done_read_control, done_multiply, busy
  );

  modport slave (
    output rd_go, M2, M1dN1, BLOCK_WIDTHdN2, BLOCKS,
    input  rd_addr_A, rd_addr_B, rd_valid, tile_first, tile_last,
           done_read_control, done_multiply, busy
  );
endinterface

// File: rtl/blocked_read_ctrl.sv
// Walks a loaded block as (i, j, k) tiles, issuing one A/B bank address pair per cycle,
// then waits out the array pipeline and signals block / multiply completion.
module blocked_read_ctrl #(
  parameter int unsigned ADDR_W_A     = 12,
  parameter int unsigned ADDR_W_B     = 12,
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned DRAIN_CYC    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  blocked_read_ctrl_if.master bus
);
  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DrainW-1:0]       DrainLast = DrainW'(DRAIN_CYC - 1);
  localparam logic [MATRIXSIZE_W-1:0] One       = MATRIXSIZE_W'(1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StDrain   = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StWaitLow = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [MATRIXSIZE_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MATRIXSIZE_W-1:0] m2_q, m2_d, m1_q, m1_d, bw_q, bw_d, blocks_q, blocks_d;
  logic [MATRIXSIZE_W-1:0] blk_q, blk_d;
  logic [ADDR_W_A-1:0]     base_a_q, base_a_d, addr_a_q, addr_a_d;
  logic [ADDR_W_B-1:0]     base_b_q, base_b_d, addr_b_q, addr_b_d;
  logic [DrainW-1:0]       drain_q, drain_d;
  logic                    valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic                    done_rc_q, done_rc_d, done_mul_q, done_mul_d;

  logic                    k_last, j_last, i_last, size_zero;
  logic [ADDR_W_A-1:0]     m2_a;
  logic [ADDR_W_B-1:0]     m2_b;

  assign k_last    = (k_q == m2_q - One);
  assign j_last    = (j_q == bw_q - One);
  assign i_last    = (i_q == m1_q - One);
  assign m2_a      = ADDR_W_A'(m2_q);
  assign m2_b      = ADDR_W_B'(m2_q);
  assign size_zero = (bus.M2 == '0) || (bus.M1dN1 == '0) || (bus.BLOCK_WIDTHdN2 == '0);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    m2_d       = m2_q;
    m1_d       = m1_q;
    bw_d       = bw_q;
    blocks_d   = blocks_q;
    blk_d      = blk_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    drain_d    = drain_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    done_rc_d  = 1'b0;
    done_mul_d = 1'b0;

    case (state_q)
      StIdle: begin
        i_d      = '0;
        j_d      = '0;
        k_d      = '0;
        base_a_d = '0;
        base_b_d = '0;
        drain_d  = '0;
        if (bus.rd_go) begin
          m2_d     = bus.M2;
          m1_d     = bus.M1dN1;
          bw_d     = bus.BLOCK_WIDTHdN2;
          blocks_d = bus.BLOCKS;
          state_d  = size_zero ? StDrain : StRead;
        end
      end
      StRead: begin
        // rd_go low pauses the walk in place; nothing advances.
        if (bus.rd_go) begin
          valid_d  = 1'b1;
          addr_a_d = base_a_q + ADDR_W_A'(k_q);
          addr_b_d = base_b_q + ADDR_W_B'(k_q);
          first_d  = (k_q == '0);
          last_d   = k_last;
          if (!k_last) begin
            k_d = k_q + One;
          end else begin
            k_d = '0;
            if (!j_last) begin
              j_d      = j_q + One;
              base_b_d = base_b_q + m2_b;
            end else begin
              j_d      = '0;
              base_b_d = '0;
              if (!i_last) begin
                i_d      = i_q + One;
                base_a_d = base_a_q + m2_a;
              end else begin
                state_d = StDrain;
              end
            end
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StDone;
        else                      drain_d = drain_q + DrainW'(1);
      end
      StDone: begin
        done_rc_d = 1'b1;
        if (blk_q == blocks_q) begin
          done_mul_d = 1'b1;
          blk_d      = '0;
        end else begin
          blk_d = blk_q + One;
        end
        state_d = StWaitLow;
      end
      StWaitLow: begin
        // Wait for rd_go to drop so the same loaded block is never read twice.
        if (!bus.rd_go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      m2_q       <= '0;
      m1_q       <= '0;
      bw_q       <= '0;
      blocks_q   <= '0;
      blk_q      <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      drain_q    <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_rc_q  <= 1'b0;
      done_mul_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      m2_q       <= m2_d;
      m1_q       <= m1_d;
      bw_q       <= bw_d;
      blocks_q   <= blocks_d;
      blk_q      <= blk_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      drain_q    <= drain_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_rc_q  <= done_rc_d;
      done_mul_q <= done_mul_d;
    end
  end

  assign bus.rd_addr_A         = addr_a_q;
  assign bus.rd_addr_B         = addr_b_q;
  assign bus.rd_valid          = valid_q;
  assign bus.tile_first        = first_q;
  assign bus.tile_last         = last_q;
  assign bus.done_read_control = done_rc_q;
  assign bus.done_multiply     = done_mul_q;
  assign bus.busy              = (state_q != StIdle);
endmodule
